uart_transmit: RTL

Serial UART transmitter, the FPGA→host counterpart of `uart_receive`. It accepts bytes from an on-chip producer, such as a CPU MMIO store or a debug path, over a valid/ready handshake. Bytes are buffered in a small FIFO and shifted out on the `uart_txd` pin as 8N1 frames at a fixed baud rate. The block sits in the 100 MHz domain alongside the receiver.

---
 rtl/uart_transmit.sv | 134 +++++++++++++
 1 files changed

// File: rtl/uart_transmit.sv
// Purpose: 8N1 UART transmitter. Bytes are queued in a FIFO and shifted out LSB first on dout.
// Latency: a push into an empty FIFO with the line idle is popped on the next edge. dout drops
//          one cycle after the push. Frames are 10*CLKS_PER_BIT cycles and follow each other
//          with no gap.
// Backpressure: din_ready is low while the FIFO holds FIFO_DEPTH bytes or reset is asserted.
// Ports: clk; rst (sync, active-low); din/din_valid/din_ready (push handshake);
//        dout (registered serial line, idle high); busy (frame in flight or FIFO non-empty);
//        fifo_count (queued bytes, not counting the byte being shifted).
module uart_transmit #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    din,
  input  logic                          din_valid,
  output logic                          din_ready,
  output logic                          dout,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL     = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    sh, sh_n;
  logic          dout_n;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          push, pop, tick, have;

  assign din_ready  = (count != FULL) && rst;
  assign push       = din_valid && din_ready;
  assign have       = (count != '0);
  assign tick       = (cnt == LAST_CNT);
  assign fifo_count = count;
  assign busy       = (state != IDLE) || have;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    sh_n    = sh;
    pop     = 1'b0;
    // The baud counter free-runs through a frame and wraps on the bit boundary;
    // it is held at zero while idle so each frame starts on a fresh count.
    cnt_n   = tick ? '0 : cnt + 1'b1;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (have) begin
          pop     = 1'b1;
          sh_n    = mem[rptr];
          state_n = START;
        end
      end
      START: begin
        if (tick) begin
          state_n = DATA;
          idx_n   = 3'd0;
        end
      end
      DATA: begin
        if (tick) begin
          if (idx == 3'd7) state_n = STOP;
          else             idx_n   = idx + 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          // Chain straight into the next start bit when more bytes are waiting.
          if (have) begin
            pop     = 1'b1;
            sh_n    = mem[rptr];
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // dout is registered from the next-state view so the line changes on the
    // same edge as the state it belongs to.
    case (state_n)
      START:   dout_n = 1'b0;
      DATA:    dout_n = sh_n[idx_n];
      default: dout_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      dout  <= 1'b1;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      sh    <= sh_n;
      dout  <= dout_n;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

endmodule
